uart_rx_framer: RTL and testbench
=================================

Name: uart_rx_framer

Overview:
- UART receive front-end that sits directly upstream of the SHA-256 message buffer.
- Deserialises 8N1 serial data from the `rx` pin into bytes. Each byte is presented on `data_out` with a one-cycle `data_valid` strobe.
- Detects end-of-message by line-idle timeout and emits a one-cycle `byte_stop` strobe. The buffer uses it to close the message and trigger padding/hashing.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal values are 8 or more.
- IDLE_BITS, 20, bit periods of continuous idle-high after the last good byte before `byte_stop` fires.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  asynchronous serial line; idles high.
- data_out  output  8  last received byte; holds until the next good byte.
- data_valid  output  1  one-cycle strobe; `data_out` is valid this cycle.
- byte_stop  output  1  one-cycle strobe; end of message (idle timeout).
- frame_err  output  1  one-cycle strobe; bad stop bit (or bad parity when enabled).
- busy  output  1  high while the FSM is outside IDLE.

Behaviour:
- Reset: the FSM goes to IDLE. `data_out`=8'h00. `data_valid`, `byte_stop`, `frame_err` and `busy` are 0. The synchroniser flops are 1. The bit counter, cycle counter and idle timer are 0. `armed`=0.
- rx passes through a 2-flop synchroniser (reset value 1). All decisions use the synchronised value `rx_s`.
- IDLE:
  - A 1->0 transition on `rx_s` enters START and clears the cycle counter.
- START:
  - At count CLKS_PER_BIT/2-1 (floor division), re-sample `rx_s`.
  - If `rx_s`=1: false start; return to IDLE and assert no strobe.
  - If `rx_s`=0: enter DATA with the bit index at 0.
- DATA:
  - Sample every CLKS_PER_BIT cycles, at mid-bit, into a shift register, LSB first.
  - After bit 7, go to PARITY (macro defined) or STOP.
- STOP:
  - Sample at mid-bit.
  - If the sample is 1: on the next cycle load `data_out`, pulse `data_valid` for 1 cycle, set `armed`=1, return to IDLE.
  - If the sample is 0: pulse `frame_err` for 1 cycle, leave `data_out` unchanged, assert no `data_valid`, enter WAIT_HIGH.
- WAIT_HIGH:
  - Stay until `rx_s`=1, then go to IDLE. A break condition therefore produces exactly one `frame_err`.
- Latency: `data_valid` rises 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the `rx` falling edge. The bench tolerance is ±1 cycle.
- Idle timer:
  - Counts only in IDLE with `armed`=1 and `rx_s`=1.
  - Clears on any 1->0 transition of `rx_s` and whenever the FSM leaves IDLE.
  - On reaching IDLE_BITS*CLKS_PER_BIT-1: pulse `byte_stop` for 1 cycle, clear `armed`, clear the timer.
- `byte_stop` never fires without at least one good byte since the previous `byte_stop` or reset. A false start does not disarm the timer, but it does restart the count.
- `data_valid`, `byte_stop` and `frame_err` are mutually exclusive in any cycle. They are never asserted for more than one cycle.
- Counter widths are sized with $clog2 so they never wrap within a bit period or within the idle window.
- Reset asserted mid-frame: return immediately to the reset state. A partial byte produces no strobe.
- `rx` held low from reset: treated as a start, then as a framing error on the stop bit, then WAIT_HIGH. No `data_valid` is produced.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - Frames are 8E1: a PARITY state samples a 9th bit at mid-bit after data bit 7.
  - If (^data)^parity != 0, the byte is discarded: `frame_err` pulses at the stop-bit sample and there is no `data_valid`.
  - A stop-bit error reports the same single `frame_err`.
  - Latency grows by CLKS_PER_BIT.
- When undefined: 8N1 only; the PARITY state and its logic are absent.

Test Plan:
- All scenarios use CLKS_PER_BIT=16 and IDLE_BITS=20.
- Bytes: send 8'h68 then 8'h69 back-to-back -> two `data_valid` pulses with `data_out`=68 then 69. After 320 cycles of idle, one `byte_stop` pulse. No `frame_err`.
- Framing error: send 8'hA5 with the stop bit driven 0 -> one `frame_err`, no `data_valid`, `data_out` keeps its previous value, `busy` stays high until `rx` returns high.
- False start: pulse `rx` low for 4 cycles in IDLE -> no strobes, FSM back in IDLE. A following 8'h3C is received correctly.
- Idle boundary: send 8'h61, then a second start after exactly 319 idle cycles -> no `byte_stop` between the bytes. Exactly one `byte_stop` 320 cycles after the second byte.
- Reset: assert `rst` during data bit 4 of 8'hFF -> all outputs 0 immediately. After release, no `data_valid` and no `byte_stop` occur. A subsequent 8'h00 is received normally.
- Parity (UART_RX_PARITY_EN defined): 8'h68 with correct parity 1 -> `data_valid`, `data_out`=68. 8'h68 with parity 0 -> `frame_err` only.

Source files
------------

// File: rtl/uart_rx_framer_if.sv
// uart_rx_framer_if
//   Output bundle of the UART receive front-end towards the SHA-256 message
//   buffer.
//   data_out   [7:0] last good byte; holds until the next good byte
//   data_valid       one-cycle strobe, data_out valid this cycle
//   byte_stop        one-cycle strobe, end of message (line idle timeout)
//   frame_err        one-cycle strobe, bad stop bit (or bad parity)
//   busy             receiver FSM is outside IDLE
//   master: driven by uart_rx_framer; slave: the consuming buffer.
interface uart_rx_framer_if;
    logic [7:0] data_out;
    logic       data_valid;
    logic       byte_stop;
    logic       frame_err;
    logic       busy;

    modport master (output data_out, data_valid, byte_stop, frame_err, busy);
    modport slave  (input  data_out, data_valid, byte_stop, frame_err, busy);
endinterface

// File: rtl/uart_rx_framer.sv
// uart_rx_framer
//   UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) with
//   end-of-message detection by line-idle timeout.
//   clk    system clock, rising edge
//   rst    asynchronous active-high reset
//   rx     asynchronous serial input, idles high
//   out_if byte / strobe / busy outputs (uart_rx_framer_if.master)
//   Parameters: CLKS_PER_BIT (>= 8), IDLE_BITS (idle bit periods before
//   byte_stop).
//   Optional build macro: UART_RX_PARITY_EN adds an even-parity bit.
module uart_rx_framer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int IDLE_BITS    = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    uart_rx_framer_if.master out_if
);
    localparam int HALF_BIT   = CLKS_PER_BIT / 2;
    localparam int IDLE_LIMIT = IDLE_BITS * CLKS_PER_BIT;
    localparam int CNT_W      = $clog2(CLKS_PER_BIT);
    localparam int IDLE_W     = $clog2(IDLE_LIMIT);

    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_LIMIT - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_HIGH = 3'd5;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY    = 3'd3;
`endif

    logic              rx_meta, rx_s, rx_prev;
    logic [2:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shreg;
    logic [7:0]        data_out_r;
    logic              data_valid_r, byte_stop_r, frame_err_r;
    logic [IDLE_W-1:0] idle_cnt;
    logic              armed;
    logic              rx_fall, bit_mid, frame_ok, stop_good;
`ifdef UART_RX_PARITY_EN
    logic              par_bit;
`endif

    // Two-flop synchroniser plus one history flop for edge detection;
    // all reset high so a line idling high never looks like a start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    always_comb begin
        rx_fall = rx_prev & ~rx_s;
        bit_mid = (cnt == BIT_LAST);
`ifdef UART_RX_PARITY_EN
        // Even parity: data XOR parity must be 0, and the stop bit high.
        frame_ok = rx_s & ~((^shreg) ^ par_bit);
`else
        frame_ok = rx_s;
`endif
        stop_good = (state == S_STOP) & bit_mid & frame_ok;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            data_out_r   <= '0;
            data_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit      <= 1'b0;
`endif
        end else begin
            data_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rx_fall) begin
                        state <= S_START;
                        cnt   <= '0;
                    end
                end
                S_START: begin
                    // Half a bit in: still low means a real start bit, and
                    // every later sample lands mid-bit.
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_mid) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (bit_mid) begin
                        cnt     <= '0;
                        par_bit <= rx_s;
                        state   <= S_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_mid) begin
                        cnt <= '0;
                        if (frame_ok) begin
                            data_out_r   <= shreg;
                            data_valid_r <= 1'b1;
                            state        <= S_IDLE;
                        end else begin
                            // One error per frame; a held break is absorbed
                            // in WAIT_HIGH instead of re-triggering starts.
                            frame_err_r <= 1'b1;
                            state       <= S_WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    if (rx_s) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Idle timer: runs only on a high line in IDLE after a good byte, so
    // byte_stop cannot fire twice without new data in between.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt    <= '0;
            armed       <= 1'b0;
            byte_stop_r <= 1'b0;
        end else begin
            byte_stop_r <= 1'b0;
            if (stop_good) armed <= 1'b1;
            if (state != S_IDLE || rx_fall) begin
                idle_cnt <= '0;
            end else if (armed && rx_s) begin
                if (idle_cnt == IDLE_LAST) begin
                    idle_cnt    <= '0;
                    armed       <= 1'b0;
                    byte_stop_r <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
        end
    end

    assign out_if.data_out   = data_out_r;
    assign out_if.data_valid = data_valid_r;
    assign out_if.byte_stop  = byte_stop_r;
    assign out_if.frame_err  = frame_err_r;
    assign out_if.busy       = (state != S_IDLE);
endmodule

// File: tb/tb_uart_rx_framer.sv
// tb_uart_rx_framer
//   Scoreboard bench for uart_rx_framer (CLKS_PER_BIT=16, IDLE_BITS=20).
//   Stimulus tasks push the expected strobe (kind, byte, cycle) into a queue;
//   a monitor pops and compares every strobe the DUT produces.
//   Honours UART_RX_PARITY_EN the same way as the design.
module tb_uart_rx_framer;
    localparam int CPB       = 16;
    localparam int IDLE_BITS = 20;
    localparam int IDLE_CYC  = CPB * IDLE_BITS;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 10;
`else
    localparam int FRAME_BITS = 9;
`endif
    // Strobe appears 2 + CPB/2 + FRAME_BITS*CPB + 1 cycles after rx falls.
    localparam int LAT  = 3 + CPB / 2 + FRAME_BITS * CPB;
    localparam int K_DV = 1;
    localparam int K_BS = 2;
    localparam int K_FE = 3;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         t;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    ev_t  exp_q[$];

    // Reference model state
    logic [7:0] last_good = 8'h00;
    bit         armed     = 1'b0;
    bit         due_valid = 1'b0;
    int         stop_due  = 0;
    int         last_dv_t = 0;

    uart_rx_framer_if bus();

    uart_rx_framer #(.CLKS_PER_BIT(CPB), .IDLE_BITS(IDLE_BITS)) dut (
        .clk    (clk),
        .rst    (rst),
        .rx     (rx),
        .out_if (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] d, input int t);
        ev_t e;
        e.kind = kind;
        e.data = d;
        e.t    = t;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Line high for n cycles; if the idle window of the last good byte
    // closes before a start could cancel it, a byte_stop is due.
    task automatic idle(input int n);
        if (armed && due_valid && stop_due <= cyc + n + 2) begin
            push(K_BS, 8'h00, stop_due);
            armed     = 1'b0;
            due_valid = 1'b0;
        end
        rx = 1'b1;
        tick(n);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_bit, input bit par_bad);
        int t0;
        bit good;
        if (armed) due_valid = 1'b0;
        t0   = cyc;
        good = stop_bit && !par_bad;
        if (good) begin
            push(K_DV, b, t0 + LAT);
            last_good = b;
            last_dv_t = t0 + LAT;
            armed     = 1'b1;
            due_valid = 1'b1;
            stop_due  = t0 + LAT + IDLE_CYC;
        end else begin
            push(K_FE, last_good, t0 + LAT);
        end
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ par_bad;
        tick(CPB);
`endif
        rx = stop_bit;
        tick(CPB);
    endtask

    initial begin : monitor
        ev_t e;
        int  n;
        int  kind;
        forever begin
            @(negedge clk);
            if (rst) continue;
            n = int'(bus.data_valid) + int'(bus.byte_stop) + int'(bus.frame_err);
            if (n == 0) continue;
            if (n > 1) check("strobe_exclusive", n, 1);
            kind = bus.data_valid ? K_DV : (bus.byte_stop ? K_BS : K_FE);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", kind, 0);
                continue;
            end
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            if (kind == e.kind && kind == K_DV) check("data_out", int'(bus.data_out), int'(e.data));
            if (kind == e.kind && kind == K_FE) check("data_out_held", int'(bus.data_out), int'(e.data));
            tests++;
            if (cyc < e.t - 1 || cyc > e.t + 1) begin
                fails++;
                $display("FAIL event_time: kind %0d got cycle %0d, expected %0d +/-1", kind, cyc, e.t);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d events pending", exp_q.size());
        $fatal(1);
    end

    initial begin : stimulus
        ev_t        e;
        logic [7:0] rb;
        bit         bad;

        // Reset state
        rst = 1'b1;
        rx  = 1'b1;
        tick(3);
        check("rst_data_out", int'(bus.data_out), 0);
        check("rst_data_valid", int'(bus.data_valid), 0);
        check("rst_byte_stop", int'(bus.byte_stop), 0);
        check("rst_frame_err", int'(bus.frame_err), 0);
        check("rst_busy", int'(bus.busy), 0);
        rst = 1'b0;
        tick(5);

        // Two bytes back-to-back, then idle timeout
        send_frame(8'h68, 1'b1, 1'b0);
        send_frame(8'h69, 1'b1, 1'b0);
        idle(400);

        // Framing error with the line held low afterwards
        send_frame(8'hA5, 1'b0, 1'b0);
        tick(40);
        check("busy_wait_high", int'(bus.busy), 1);
        check("data_out_after_ferr", int'(bus.data_out), int'(last_good));
        rx = 1'b1;
        tick(6);
        check("busy_released", int'(bus.busy), 0);

        // False start, then a normal byte
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(30);
        check("busy_after_false_start", int'(bus.busy), 0);
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(400);

        // Idle boundary: the next start lands on the last count before timeout
        send_frame(8'h61, 1'b1, 1'b0);
        idle(last_dv_t + IDLE_CYC - 3 - cyc);
        send_frame(8'h62, 1'b1, 1'b0);
        idle(400);

        // Reset during data bit 4 of 0xFF
        rx = 1'b0;
        tick(CPB);
        rx = 1'b1;
        tick(4 * CPB + CPB / 2);
        rst = 1'b1;
        #1;
        check("midrst_data_out", int'(bus.data_out), 0);
        check("midrst_data_valid", int'(bus.data_valid), 0);
        check("midrst_byte_stop", int'(bus.byte_stop), 0);
        check("midrst_frame_err", int'(bus.frame_err), 0);
        check("midrst_busy", int'(bus.busy), 0);
        last_good = 8'h00;
        armed     = 1'b0;
        due_valid = 1'b0;
        tick(3);
        rst = 1'b0;
        idle(400);
        send_frame(8'h00, 1'b1, 1'b0);
        idle(400);

`ifdef UART_RX_PARITY_EN
        // Bad parity discards the byte, good parity delivers it
        send_frame(8'h68, 1'b1, 1'b1);
        idle(10);
        send_frame(8'h68, 1'b1, 1'b0);
        idle(400);
`endif

        // Random bytes with random gaps and occasional broken stop bits
        for (int k = 0; k < 8; k++) begin
            rb  = 8'($urandom);
            bad = (k != 7) && ($urandom_range(0, 3) == 0);
            send_frame(rb, !bad, 1'b0);
            if (bad) begin
                tick($urandom_range(1, 30));
                idle($urandom_range(6, 60));
            end else begin
                idle($urandom_range(0, 80));
            end
        end
        idle(400);
        tick(50);

        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            fails++;
            $display("FAIL missing_event: kind %0d expected at cycle %0d, not seen", e.kind, e.t);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
